// File: rtl/elevator_sched.sv
// elevator_sched: single-car SCAN elevator scheduler driven by a slow tick time base
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tick_in   slow square wave, synchronised and rising-edge detected internally
//   req       request buttons, bit i = floor i (level or pulse)
//   floor     current car floor
//   dir_up    current/last travel direction (1 = up)
//   moving    high while the car travels between floors
//   door_open high while the door is open
//   pending   latched outstanding requests
module elevator_sched #(
  parameter int NUM_FLOORS = 4,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_in,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FW-1:0]         floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] floor_n, step_floor;
  logic dir_n;
  logic s1, s2, s3, tick_p;
  logic [NUM_FLOORS-1:0] pend_now, clr;
  // True when any request in p lies strictly beyond floor f in the given direction.
  function automatic logic ahead(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f, input logic up);
    ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) ahead = 1'b1;
  endfunction
  // s1/s2 synchronise, s3 holds the previous level for rising-edge detection.
  assign tick_p = s2 & ~s3;
  assign pend_now = pending | req;
  assign step_floor = dir_up ? floor + FW'(1) : floor - FW'(1);
  assign moving = (state == MOVE);
  assign door_open = (state == DOOR);
  always_comb begin
    state_n = state;
    floor_n = floor;
    dir_n = dir_up;
    cnt_n = cnt;
    clr = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pend_now[floor]) begin
          state_n = DOOR;
          clr[floor] = 1'b1;
        end else if (ahead(pend_now, floor, dir_up)) begin
          state_n = MOVE;
        end else if (ahead(pend_now, floor, ~dir_up)) begin
          dir_n = ~dir_up;
          state_n = MOVE;
        end
      end
      MOVE: begin
        if (tick_p) begin
          if (cnt == CW'(MOVE_TICKS - 1)) begin
            cnt_n = '0;
            floor_n = step_floor;
            if (pend_now[step_floor]) begin
              state_n = DOOR;
              clr[step_floor] = 1'b1;
            end else if (!ahead(pend_now, step_floor, dir_up)) begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      DOOR: begin
        // A new request at this floor keeps the door open for a full period again.
        if (pend_now[floor]) begin
          clr[floor] = 1'b1;
          cnt_n = '0;
        end else if (tick_p) begin
          if (cnt == CW'(DOOR_TICKS - 1)) begin
            cnt_n = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      floor <= '0;
      dir_up <= 1'b1;
      cnt <= '0;
      pending <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      state <= state_n;
      floor <= floor_n;
      dir_up <= dir_n;
      cnt <= cnt_n;
      pending <= pend_now & ~clr;
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end
endmodule

// File: tb/tb_elevator_sched.sv
// tb_elevator_sched: table-driven scoreboard bench for elevator_sched
module tb_elevator_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_in = 1'b0;
  logic [3:0] req = '0;
  logic [1:0] floor;
  logic dir_up, moving, door_open;
  logic [3:0] pending;
  int errors = 0;
  int checks = 0;
  typedef struct {
    string name;
    logic [3:0] req;
    int ticks;
    logic [10:0] exp;
  } step_t;
  step_t tab_a[$];
  step_t tab_b[$];
  logic [10:0] sb[$];
  always #5 clk = ~clk;
  elevator_sched #(.NUM_FLOORS(4), .MOVE_TICKS(2), .DOOR_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .req(req),
    .floor(floor), .dir_up(dir_up), .moving(moving), .door_open(door_open), .pending(pending)
  );
  // Packed expectation: {floor, dir_up, moving, door_open, pending}
  function automatic logic [10:0] st(int f, bit d, bit m, bit o, logic [3:0] p);
    return {2'(f), d, m, o, p};
  endfunction
  function automatic step_t mk(string n, logic [3:0] r, int t, logic [10:0] e);
    step_t s;
    s.name = n;
    s.req = r;
    s.ticks = t;
    s.exp = e;
    return s;
  endfunction
  task automatic compare(input string name);
    logic [10:0] exp, act;
    act = {floor, dir_up, moving, door_open, pending};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, expected floor=%0d dir_up=%b moving=%b door_open=%b pending=%b",
                 name, act[10:9], act[8], act[7], act[6], act[5:0] & 6'hf,
                 exp[10:9], exp[8], exp[7], exp[6], exp[3:0]);
      end
    end
  endtask
  task automatic tick_pulses(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic square(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask
  task automatic run_step(input step_t s);
    @(negedge clk);
    req = s.req;
    sb.push_back(s.exp);
    @(negedge clk);
    req = '0;
    tick_pulses(s.ticks);
    repeat (2) @(negedge clk);
    compare(s.name);
  endtask
  initial begin
    tab_a.push_back(mk("req3_go",       4'b1000, 0, st(0, 1, 1, 0, 4'b1000)));
    tab_a.push_back(mk("up_f1",         4'b0000, 2, st(1, 1, 1, 0, 4'b1000)));
    tab_a.push_back(mk("up_f2",         4'b0000, 2, st(2, 1, 1, 0, 4'b1000)));
    tab_a.push_back(mk("arrive_f3",     4'b0000, 2, st(3, 1, 0, 1, 4'b0000)));
    tab_a.push_back(mk("door_hold",     4'b0000, 2, st(3, 1, 0, 1, 4'b0000)));
    tab_a.push_back(mk("door_close",    4'b0000, 1, st(3, 1, 0, 0, 4'b0000)));
    tab_a.push_back(mk("req_here",      4'b1000, 0, st(3, 1, 0, 1, 4'b0000)));
    tab_a.push_back(mk("here_close",    4'b0000, 3, st(3, 1, 0, 0, 4'b0000)));
    tab_a.push_back(mk("flip_down",     4'b0001, 0, st(3, 0, 1, 0, 4'b0001)));
    tab_a.push_back(mk("down_f2",       4'b0000, 2, st(2, 0, 1, 0, 4'b0001)));
    tab_a.push_back(mk("add_f1",        4'b0010, 0, st(2, 0, 1, 0, 4'b0011)));
    tab_a.push_back(mk("stop_f1",       4'b0000, 2, st(1, 0, 0, 1, 4'b0001)));
    tab_a.push_back(mk("resume_down",   4'b0000, 3, st(1, 0, 1, 0, 4'b0001)));
    tab_a.push_back(mk("arrive_f0",     4'b0000, 2, st(0, 0, 0, 1, 4'b0000)));
    tab_a.push_back(mk("door_2ticks",   4'b0000, 2, st(0, 0, 0, 1, 4'b0000)));
    tab_a.push_back(mk("door_restart",  4'b0001, 0, st(0, 0, 0, 1, 4'b0000)));
    tab_a.push_back(mk("restart_hold",  4'b0000, 2, st(0, 0, 0, 1, 4'b0000)));
    tab_a.push_back(mk("restart_close", 4'b0000, 1, st(0, 0, 0, 0, 4'b0000)));
    tab_a.push_back(mk("flip_up",       4'b0100, 0, st(0, 1, 1, 0, 4'b0100)));
    tab_a.push_back(mk("up_f1_b",       4'b0000, 2, st(1, 1, 1, 0, 4'b0100)));
    tab_b.push_back(mk("t3_go",         4'b1000, 0, st(0, 1, 1, 0, 4'b1000)));
    tab_b.push_back(mk("t3_f1",         4'b0000, 2, st(1, 1, 1, 0, 4'b1000)));
    tab_b.push_back(mk("t3_req0",       4'b0001, 0, st(1, 1, 1, 0, 4'b1001)));
    tab_b.push_back(mk("t3_serve3",     4'b0000, 4, st(3, 1, 0, 1, 4'b0001)));
    tab_b.push_back(mk("t3_flip",       4'b0000, 3, st(3, 0, 1, 0, 4'b0001)));
    tab_b.push_back(mk("t3_arrive0",    4'b0000, 6, st(0, 0, 0, 1, 4'b0000)));
    tab_b.push_back(mk("t3_close",      4'b0000, 3, st(0, 0, 0, 0, 4'b0000)));
    repeat (3) @(negedge clk);
    sb.push_back(st(0, 1, 0, 0, 4'b0000));
    compare("reset_state");
    rst_n = 1'b1;
    foreach (tab_a[i]) run_step(tab_a[i]);
    tick_pulses(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.push_back(st(0, 1, 0, 0, 4'b0000));
    #1 compare("async_reset_mid_move");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back(st(0, 1, 0, 0, 4'b0000));
    compare("post_reset_idle");
    foreach (tab_b[i]) run_step(tab_b[i]);
    @(negedge clk);
    req = 4'b0010;
    sb.push_back(st(0, 1, 1, 0, 4'b0010));
    @(negedge clk);
    req = '0;
    compare("t6_go");
    tick_in = 1'b1;
    repeat (20) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back(st(0, 1, 1, 0, 4'b0010));
    compare("t6_long_high_one_tick");
    square(1);
    repeat (4) @(negedge clk);
    sb.push_back(st(1, 1, 0, 1, 4'b0000));
    compare("t6_second_rise");
    square(3);
    repeat (4) @(negedge clk);
    sb.push_back(st(1, 1, 0, 0, 4'b0000));
    compare("t6_door_close");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
